// File: rtl/mesh4x4_noc_if.sv
// PE-side injection/ejection bundle for all 16 mesh nodes.
// Index N of every array belongs to node rN at x = N%4, y = N/4.
interface mesh4x4_noc_if;
  logic [15:0] pesi;
  logic [63:0] pedi [16];
  logic [15:0] peri;
  logic [15:0] pero;
  logic [63:0] pedo [16];
  logic [15:0] peso;

  modport master (
    output pesi, pedi, pero,
    input  peri, pedo, peso
  );

  modport slave (
    input  pesi, pedi, pero,
    output peri, pedo, peso
  );
endinterface

// File: rtl/mesh4x4_noc.sv
// 4x4 XY mesh of five-port, two-VC routers with 1-entry buffers.
// Each VC alternates crossbar and link phases on a shared polarity bit.
module mesh4x4_noc #(
  parameter int DATA_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  output logic         polarity,
  mesh4x4_noc_if.slave pe
);
  localparam int NN  = 16;
  localparam int NP  = 5;
  localparam int NV  = 2;
  localparam int NB  = NN * NP * NV;
  localparam int P_N = 0;
  localparam int P_S = 1;
  localparam int P_E = 2;
  localparam int P_W = 3;
  localparam int P_L = 4;

  logic              pol_q;
  logic [NB-1:0]     ifull_q, ifull_d;
  logic [NB-1:0]     ofull_q, ofull_d;
  logic [DATA_W-1:0] idat_q [NB];
  logic [DATA_W-1:0] idat_d [NB];
  logic [DATA_W-1:0] odat_q [NB];
  logic [DATA_W-1:0] odat_d [NB];
  logic [2:0]        rr_q [NB];
  logic [2:0]        rr_d [NB];

  function automatic int ix(input int n, input int p, input int v);
    return (n * NP + p) * NV + v;
  endfunction

  // Downstream node reached through port p, or -1 at a mesh edge.
  function automatic int nbr(input int n, input int p);
    int x, y;
    x = n % 4;
    y = n / 4;
    case (p)
      P_N:     return (y < 3) ? n + 4 : -1;
      P_S:     return (y > 0) ? n - 4 : -1;
      P_E:     return (x < 3) ? n + 1 : -1;
      default: return (x > 0) ? n - 1 : -1;
    endcase
  endfunction

  function automatic int rport(input logic [DATA_W-1:0] p);
    if (p[55:52] != 4'd0) return p[62] ? P_E : P_W;
    if (p[51:48] != 4'd0) return p[61] ? P_N : P_S;
    return P_L;
  endfunction

  function automatic logic [DATA_W-1:0] hop(input logic [DATA_W-1:0] p);
    logic [DATA_W-1:0] r;
    r = p;
    if (p[55:52] != 4'd0)      r[55:52] = p[55:52] - 4'd1;
    else if (p[51:48] != 4'd0) r[51:48] = p[51:48] - 4'd1;
    return r;
  endfunction

  always_comb begin
    int  b, m, w;
    logic hit;
    ifull_d = ifull_q;
    ofull_d = ofull_q;
    idat_d  = idat_q;
    odat_d  = odat_q;
    rr_d    = rr_q;
    b   = 0;
    m   = 0;
    w   = 0;
    hit = 1'b0;
    for (int n = 0; n < NN; n++) begin
      for (int v = 0; v < NV; v++) begin
        if (pol_q == 1'(v)) begin
          for (int p = 0; p < 4; p++) begin
            b = ix(n, p, v);
            m = nbr(n, p);
            if (ofull_q[b] && m >= 0) begin
              if (!ifull_q[ix(m, p ^ 1, v)]) begin
                ifull_d[ix(m, p ^ 1, v)] = 1'b1;
                idat_d[ix(m, p ^ 1, v)]  = odat_q[b];
                ofull_d[b]               = 1'b0;
              end
            end
          end
          if (pe.pero[n]) ofull_d[ix(n, P_L, v)] = 1'b0;
        end else begin
          for (int o = 0; o < NP; o++) begin
            hit = 1'b0;
            w   = 0;
            for (int k = 0; k < NP; k++) begin
              b = (int'(rr_q[ix(n, o, v)]) + k) % NP;
              if (!hit && ifull_q[ix(n, b, v)] &&
                  rport(idat_q[ix(n, b, v)]) == o) begin
                hit = 1'b1;
                w   = b;
              end
            end
            if (hit && !ofull_q[ix(n, o, v)]) begin
              ofull_d[ix(n, o, v)] = 1'b1;
              odat_d[ix(n, o, v)]  = hop(idat_q[ix(n, w, v)]);
              ifull_d[ix(n, w, v)] = 1'b0;
              rr_d[ix(n, o, v)]    = 3'((w + 1) % NP);
            end
          end
        end
      end
      if (pe.pesi[n] && pe.peri[n]) begin
        b = ix(n, P_L, int'(pe.pedi[n][63]));
        ifull_d[b] = 1'b1;
        idat_d[b]  = pe.pedi[n];
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NN; n++) begin
      pe.peri[n] = !ifull_q[ix(n, P_L, int'(pe.pedi[n][63]))];
      pe.peso[n] = ofull_q[ix(n, P_L, int'(pol_q))] && pe.pero[n];
      pe.pedo[n] = (ofull_q[ix(n, P_L, int'(pol_q))] && pe.pero[n])
                   ? odat_q[ix(n, P_L, int'(pol_q))] : '0;
    end
  end

  assign polarity = pol_q;

  always_ff @(posedge clk) begin
    idat_q <= idat_d;
    odat_q <= odat_d;
    if (reset) begin
      pol_q   <= 1'b0;
      ifull_q <= '0;
      ofull_q <= '0;
      rr_q    <= '{default: '0};
    end else begin
      pol_q   <= !pol_q;
      ifull_q <= ifull_d;
      ofull_q <= ofull_d;
      rr_q    <= rr_d;
    end
  end
endmodule

// File: tb/tb_mesh4x4_noc.sv
// Directed bench for mesh4x4_noc: per-destination scoreboard of
// expected deliveries plus hand-computed packet and latency checks.
module tb_mesh4x4_noc;
  typedef struct {
    logic [63:0] pkt;
    int          cyc;
  } ent_t;

  logic clk;
  logic reset;
  logic polarity;
  mesh4x4_noc_if pe ();

  mesh4x4_noc dut (
    .clk     (clk),
    .reset   (reset),
    .polarity(polarity),
    .pe      (pe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t        exp_q [16][$];
  logic [63:0] tx_pkt [16][32];
  int          tx_n [16];
  int          tx_i [16];
  int          dlv_cnt [16];
  logic [63:0] dlv_last [16];
  int          dlv_lat [16];
  int          stall [16];
  int          checks, errors, cyc, peri_low;
  logic        pol_m, prev_rst, started, rst_m;
  logic [15:0] pero_m;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] mk(input int s, input int d,
                                     input int vc, input logic [31:0] pay);
    logic [63:0] p;
    int dx, dy;
    dx = d % 4 - s % 4;
    dy = d / 4 - s / 4;
    p = '0;
    p[63] = vc[0];
    p[62] = (dx >= 0);
    p[61] = (dy >= 0);
    p[55:52] = 4'(dx < 0 ? -dx : dx);
    p[51:48] = 4'(dy < 0 ? -dy : dy);
    p[47:40] = 8'(s % 4);
    p[39:32] = 8'(s / 4);
    p[31:0] = pay;
    return p;
  endfunction

  function automatic int dest(input int s, input logic [63:0] p);
    int hx, hy, x, y;
    hx = int'(p[55:52]);
    hy = int'(p[51:48]);
    x = p[62] ? s % 4 + hx : s % 4 - hx;
    y = p[61] ? s / 4 + hy : s / 4 - hy;
    return y * 4 + x;
  endfunction

  function automatic bit busy();
    for (int n = 0; n < 16; n++)
      if (exp_q[n].size() != 0 || tx_i[n] != tx_n[n]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int total();
    int t;
    t = 0;
    for (int n = 0; n < 16; n++) t += dlv_cnt[n];
    return t;
  endfunction

  task automatic tick();
    int   k;
    ent_t e;
    @(negedge clk);
    #1;
    reset   = rst_m;
    pe.pero = pero_m;
    for (int n = 0; n < 16; n++) begin
      if (!rst_m && tx_i[n] < tx_n[n]) begin
        pe.pesi[n] = 1'b1;
        pe.pedi[n] = tx_pkt[n][tx_i[n]];
      end else begin
        pe.pesi[n] = 1'b0;
        pe.pedi[n] = '0;
      end
    end
    #2;
    if (started) begin
      chk("polarity", 64'(polarity), 64'(pol_m));
      if (prev_rst) chk("peri_after_reset", 64'(pe.peri), 64'hffff);
      for (int n = 0; n < 16; n++) begin
        if (pe.peso[n]) begin
          k = -1;
          for (int i = 0; i < exp_q[n].size(); i++)
            if (k < 0 && exp_q[n][i].pkt == pe.pedo[n]) k = i;
          checks++;
          if (k < 0 || !pe.pero[n]) begin
            errors++;
            $display("FAIL deliver_r%0d actual=%h pero=%b required=pending_packet_with_pero",
                     n, pe.pedo[n], pe.pero[n]);
          end
          if (k >= 0) begin
            dlv_cnt[n]++;
            dlv_last[n] = pe.pedo[n];
            dlv_lat[n]  = cyc - exp_q[n][k].cyc;
            exp_q[n].delete(k);
          end
        end else begin
          chk($sformatf("pedo_r%0d_idle", n), pe.pedo[n], 64'h0);
        end
      end
    end
    for (int n = 0; n < 16; n++) begin
      if (!pe.peri[n]) peri_low++;
      if (pe.pesi[n] && pe.peri[n] && !rst_m) begin
        e.pkt = pe.pedi[n];
        e.pkt[55:48] = 8'h00;
        e.cyc = cyc;
        exp_q[dest(n, pe.pedi[n])].push_back(e);
        tx_i[n]++;
      end else if (pe.pesi[n]) begin
        stall[n]++;
      end
      if (rst_m) exp_q[n].delete();
    end
    pol_m    = rst_m ? 1'b0 : !pol_m;
    prev_rst = rst_m;
    if (rst_m) started = 1'b1;
    cyc++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t;
    t = 0;
    while (busy() && t < budget) begin
      tick();
      t++;
    end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL %s_drain actual=pending required=idle", name);
    end
  endtask

  task automatic send(input int s, input logic [63:0] p);
    tx_pkt[s][tx_n[s]] = p;
    tx_n[s]++;
  endtask

  initial begin
    int base, b10;
    int bc [16];
    checks = 0; errors = 0; cyc = 0; peri_low = 0;
    started = 1'b0; prev_rst = 1'b0; pol_m = 1'b0;
    rst_m = 1'b1; reset = 1'b1;
    pero_m = 16'hffff; pe.pero = 16'hffff; pe.pesi = '0;
    for (int n = 0; n < 16; n++) begin
      pe.pedi[n] = '0; tx_n[n] = 0; tx_i[n] = 0;
      dlv_cnt[n] = 0; dlv_last[n] = '0; dlv_lat[n] = 0; stall[n] = 0;
    end

    tick(); tick();
    chk("reset_polarity", 64'(polarity), 64'h0);
    chk("reset_peso", 64'(pe.peso), 64'h0);
    rst_m = 1'b0;
    tick();
    tick();
    chk("pol_after_release_1", 64'(polarity), 64'h1);
    tick();
    chk("pol_after_release_2", 64'(polarity), 64'h0);
    tick();
    chk("pol_after_release_3", 64'(polarity), 64'h1);

    base = total();
    send(5, 64'h0011_0101_1111_1111);
    wait_idle("single", 30);
    chk("single_count_r0", 64'(dlv_cnt[0]), 64'h1);
    chk("single_count_all", 64'(total() - base), 64'h1);
    chk("single_pkt", dlv_last[0], 64'h0000_0101_1111_1111);
    chk("single_latency_le8", 64'(dlv_lat[0] <= 8), 64'h1);

    base = total();
    send(0, 64'h6022_0000_1111_1111);
    wait_idle("long", 30);
    chk("long_count_r10", 64'(dlv_cnt[10]), 64'h1);
    chk("long_count_all", 64'(total() - base), 64'h1);
    chk("long_pkt", dlv_last[10], 64'h6000_0000_1111_1111);
    chk("long_latency_le12", 64'(dlv_lat[10] <= 12), 64'h1);

    b10 = dlv_cnt[10];
    base = total();
    peri_low = 0;
    for (int n = 0; n < 16; n++)
      if (n != 10) send(n, mk(n, 10, n % 2, 32'hA000_0000 + 32'(n)));
    wait_idle("hotspot", 300);
    chk("hotspot_count_r10", 64'(dlv_cnt[10] - b10), 64'd15);
    chk("hotspot_count_all", 64'(total() - base), 64'd15);
    chk("hotspot_peri_dropped", 64'(peri_low > 0), 64'h1);
    tick();
    chk("hotspot_peri_recovered", 64'(pe.peri), 64'hffff);

    b10 = dlv_cnt[10];
    stall[0] = 0;
    pero_m[10] = 1'b0;
    for (int k = 0; k < 12; k++)
      send(0, mk(0, 10, 0, 32'hC000_0000 + 32'(k)));
    repeat (40) tick();
    chk("bp_no_delivery", 64'(dlv_cnt[10] - b10), 64'h0);
    chk("bp_peso_low", 64'(pe.peso[10]), 64'h0);
    chk("bp_peri_dropped", 64'(stall[0] > 0), 64'h1);
    chk("bp_inject_blocked", 64'(tx_i[0] < tx_n[0]), 64'h1);
    pero_m[10] = 1'b1;
    wait_idle("backpressure", 300);
    chk("bp_count_r10", 64'(dlv_cnt[10] - b10), 64'd12);

    for (int n = 0; n < 16; n++) bc[n] = dlv_cnt[n];
    for (int d = 0; d < 16; d++)
      if (d != 5) send(5, mk(5, d, d % 2, 32'hB000_0000 + 32'(d)));
    wait_idle("broadcast", 400);
    for (int d = 0; d < 16; d++) begin
      if (d != 5) begin
        chk($sformatf("bcast_count_r%0d", d), 64'(dlv_cnt[d] - bc[d]), 64'h1);
        chk($sformatf("bcast_payload_r%0d", d), 64'(dlv_last[d][31:0]),
            64'h0000_0000_B000_0000 + 64'(d));
      end
    end
    chk("bcast_count_r5", 64'(dlv_cnt[5] - bc[5]), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
